// File: rtl/cpu_pkg.sv
// Shared types for the fetch front end: pc_gen state encoding and
// instruction alignment mask.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pc_gen_state_e;

  localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending redirect buffer: captures trap/redirect events while the
// fetch request is blocked, newest event wins, trap beats redirect.
module pc_redirect_buf #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               capture_i,
  input  logic               clear_i,
  input  logic               trap_valid_i,
  input  logic [width_p-1:0] trap_vector_i,
  input  logic               redirect_valid_i,
  input  logic [width_p-1:0] redirect_target_i,
  output logic               pend_valid_o,
  output logic [width_p-1:0] pend_target_o,
  output logic               pend_trap_o
);

  logic               r_valid;
  logic [width_p-1:0] r_target;
  logic               r_trap;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid  <= 1'b0;
      r_target <= '0;
      r_trap   <= 1'b0;
    end else if (capture_i && (trap_valid_i || redirect_valid_i)) begin
      r_valid  <= 1'b1;
      r_target <= trap_valid_i ? trap_vector_i : redirect_target_i;
      r_trap   <= trap_valid_i;
    end else if (clear_i) begin
      r_valid  <= 1'b0;
      r_trap   <= 1'b0;
    end
  end

  assign pend_valid_o  = r_valid;
  assign pend_target_o = r_target;
  assign pend_trap_o   = r_trap;

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator with IMEM valid/ready handshake, trap/redirect
// priority, epoch tagging and misaligned-target fault. Optional performance
// counters are enabled by defining PC_GEN_PERF_CNT_EN.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int               width_p        = 32,
  parameter logic [width_p-1:0] reset_vector_p = '0,
  parameter int               inc_p          = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               redirect_valid_i,
  input  logic [width_p-1:0] redirect_target_i,
  input  logic               trap_valid_i,
  input  logic [width_p-1:0] trap_vector_i,
  input  logic               req_ready_i,
  output logic               req_valid_o,
  output logic [width_p-1:0] pc_o,
  output logic               epoch_o,
  output logic               misaligned_o,
`ifdef PC_GEN_PERF_CNT_EN
  output logic [31:0]        fetch_cnt_o,
  output logic [31:0]        redirect_cnt_o,
  output logic [31:0]        stall_cnt_o,
`endif
  output logic [width_p-1:0] bad_addr_o
);

  localparam logic [width_p-1:0] INC_W = width_p'(inc_p);

  pc_gen_state_e      r_state, w_state_next;
  logic [width_p-1:0] r_pc, w_pc_next;
  logic               r_epoch, w_epoch_next;
  logic               r_misaligned, w_misaligned_next;
  logic [width_p-1:0] r_bad_addr, w_bad_addr_next;

  logic               w_req_valid, w_fire, w_blocked;
  logic               w_pend_valid, w_pend_trap;
  logic [width_p-1:0] w_pend_target;
  logic               w_sel_valid, w_sel_trap, w_sel_bad;
  logic [width_p-1:0] w_sel_target;
  logic               w_apply, w_reject;

  assign w_req_valid = (r_state == RUN) && !stall_i;
  assign w_fire      = w_req_valid && req_ready_i;
  assign w_blocked   = w_req_valid && !req_ready_i;

  pc_redirect_buf #(.width_p(width_p)) u_pend (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .capture_i         (w_blocked),
    .clear_i           (w_apply || w_reject),
    .trap_valid_i      (trap_valid_i),
    .trap_vector_i     (trap_vector_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .pend_valid_o      (w_pend_valid),
    .pend_target_o     (w_pend_target),
    .pend_trap_o       (w_pend_trap)
  );

  // Live trap, then live redirect, then whatever is parked in the buffer.
  assign w_sel_valid  = trap_valid_i || redirect_valid_i || w_pend_valid;
  assign w_sel_trap   = trap_valid_i ? 1'b1 : (redirect_valid_i ? 1'b0 : w_pend_trap);
  assign w_sel_target = trap_valid_i     ? trap_vector_i :
                        redirect_valid_i ? redirect_target_i : w_pend_target;
  assign w_sel_bad    = !w_sel_trap && ((w_sel_target[1:0] & INSTR_ALIGN_MASK) != 2'b00);
  assign w_apply      = !w_blocked && w_sel_valid && !w_sel_bad;
  assign w_reject     = !w_blocked && w_sel_valid && w_sel_bad;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= BOOT;
      r_pc         <= reset_vector_p;
      r_epoch      <= 1'b0;
      r_misaligned <= 1'b0;
      r_bad_addr   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_epoch      <= w_epoch_next;
      r_misaligned <= w_misaligned_next;
      r_bad_addr   <= w_bad_addr_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_epoch_next      = r_epoch;
    w_misaligned_next = 1'b0;
    w_bad_addr_next   = r_bad_addr;
    case (r_state)
      BOOT:    w_state_next = RUN;
      RUN:     w_state_next = RUN;
      FAULT:   w_state_next = FAULT;
      default: w_state_next = BOOT;
    endcase
    if (w_apply) begin
      w_pc_next    = w_sel_target;
      w_epoch_next = !r_epoch;
      w_state_next = RUN;
    end else if (w_reject) begin
      w_misaligned_next = 1'b1;
      w_bad_addr_next   = w_sel_target;
      w_state_next      = FAULT;
    end else if (w_fire) begin
      w_pc_next = r_pc + INC_W;
    end
  end

`ifdef PC_GEN_PERF_CNT_EN
  logic [31:0] r_fetch_cnt, r_redirect_cnt, r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_cnt    <= '0;
      r_redirect_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (w_fire)                       r_fetch_cnt    <= r_fetch_cnt + 32'd1;
      if (w_apply)                      r_redirect_cnt <= r_redirect_cnt + 32'd1;
      if (stall_i && (r_state == RUN))  r_stall_cnt    <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o    = r_fetch_cnt;
  assign redirect_cnt_o = r_redirect_cnt;
  assign stall_cnt_o    = r_stall_cnt;
`endif

  assign req_valid_o  = w_req_valid;
  assign pc_o         = r_pc;
  assign epoch_o      = r_epoch;
  assign misaligned_o = r_misaligned;
  assign bad_addr_o   = r_bad_addr;

endmodule

// File: tb/tb_pc_gen.sv
// Directed, table-driven bench for pc_gen: one row per clock cycle with
// hand-computed expected outputs, plus hand-written reset-mid-handshake sequence.
module tb_pc_gen;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic        trap_valid_i;
  logic [31:0] trap_vector_i;
  logic        req_ready_i;
  logic        req_valid_o;
  logic [31:0] pc_o;
  logic        epoch_o;
  logic        misaligned_o;
  logic [31:0] bad_addr_o;
`ifdef PC_GEN_PERF_CNT_EN
  logic [31:0] fetch_cnt_o, redirect_cnt_o, stall_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  pc_gen #(.width_p(32), .reset_vector_p(32'h0), .inc_p(4)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .stall_i           (stall_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .trap_valid_i      (trap_valid_i),
    .trap_vector_i     (trap_vector_i),
    .req_ready_i       (req_ready_i),
    .req_valid_o       (req_valid_o),
    .pc_o              (pc_o),
    .epoch_o           (epoch_o),
    .misaligned_o      (misaligned_o),
`ifdef PC_GEN_PERF_CNT_EN
    .fetch_cnt_o       (fetch_cnt_o),
    .redirect_cnt_o    (redirect_cnt_o),
    .stall_cnt_o       (stall_cnt_o),
`endif
    .bad_addr_o        (bad_addr_o)
  );

  typedef struct {
    logic        stall;
    logic        ready;
    logic        rv;
    logic [31:0] rt;
    logic        tv;
    logic [31:0] tvec;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_ep;
    logic        e_mis;
    logic [31:0] e_bad;
    logic        app;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic st, input logic rdy, input logic rv, input logic [31:0] rt,
                     input logic tv, input logic [31:0] tvec, input logic ev,
                     input logic [31:0] epc, input logic eep, input logic emis,
                     input logic [31:0] ebad, input logic app);
    vec_t v;
    v.stall = st; v.ready = rdy; v.rv = rv; v.rt = rt; v.tv = tv; v.tvec = tvec;
    v.e_valid = ev; v.e_pc = epc; v.e_ep = eep; v.e_mis = emis; v.e_bad = ebad; v.app = app;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic rdy, input logic rv,
                       input logic [31:0] rt, input logic tv, input logic [31:0] tvec);
    rst_i = r; stall_i = st; req_ready_i = rdy;
    redirect_valid_i = rv; redirect_target_i = rt;
    trap_valid_i = tv; trap_vector_i = tvec;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc,
                         input logic eep, input logic emis, input logic [31:0] ebad);
    chk({tag, " req_valid"},  {31'd0, req_valid_o},  {31'd0, ev});
    chk({tag, " pc"},         pc_o,                  epc);
    chk({tag, " epoch"},      {31'd0, epoch_o},      {31'd0, eep});
    chk({tag, " misaligned"}, {31'd0, misaligned_o}, {31'd0, emis});
    chk({tag, " bad_addr"},   bad_addr_o,            ebad);
  endtask

  initial begin
    int e_fetch, e_redir, e_stall;
    e_fetch = 0; e_redir = 0; e_stall = 0;

    //  st rdy rv rt            tv tvec          | val pc            ep mis bad           app
    add(0, 1, 0, 32'h0,       0, 32'h0,         0, 32'h0,         0, 0, 32'h0,       0); // r0 BOOT
    add(0, 1, 0, 32'h0,       0, 32'h0,         1, 32'h0,         0, 0, 32'h0,       0);
    add(0, 1, 0, 32'h0,       0, 32'h0,         1, 32'h4,         0, 0, 32'h0,       0);
    add(0, 1, 0, 32'h0,       0, 32'h0,         1, 32'h8,         0, 0, 32'h0,       0);
    add(0, 1, 0, 32'h0,       0, 32'h0,         1, 32'hC,         0, 0, 32'h0,       0);
    add(0, 0, 0, 32'h0,       0, 32'h0,         1, 32'h10,        0, 0, 32'h0,       0); // r5 blocked
    add(0, 0, 1, 32'h100,     0, 32'h0,         1, 32'h10,        0, 0, 32'h0,       0); // captured
    add(0, 0, 0, 32'h0,       0, 32'h0,         1, 32'h10,        0, 0, 32'h0,       0);
    add(0, 1, 0, 32'h0,       0, 32'h0,         1, 32'h10,        0, 0, 32'h0,       1); // fires, pending applies
    add(0, 1, 1, 32'h300,     1, 32'h200,       1, 32'h100,       1, 0, 32'h0,       1); // trap beats redirect
    add(0, 1, 0, 32'h0,       0, 32'h0,         1, 32'h200,       0, 0, 32'h0,       0);
    add(0, 1, 1, 32'h102,     0, 32'h0,         1, 32'h204,       0, 0, 32'h0,       0); // misaligned
    add(0, 1, 0, 32'h0,       0, 32'h0,         0, 32'h204,       0, 1, 32'h102,     0); // FAULT pulse
    add(0, 1, 0, 32'h0,       1, 32'h80,        0, 32'h204,       0, 0, 32'h102,     1); // trap exits
    add(0, 1, 0, 32'h0,       0, 32'h0,         1, 32'h80,        1, 0, 32'h102,     0);
    add(0, 1, 1, 32'h40,      0, 32'h0,         1, 32'h84,        1, 0, 32'h102,     1);
    add(1, 1, 0, 32'h0,       0, 32'h0,         0, 32'h40,        0, 0, 32'h102,     0); // r16 stall 1
    add(1, 1, 1, 32'h500,     0, 32'h0,         0, 32'h40,        0, 0, 32'h102,     1); // stall 2 redirect
    add(1, 1, 0, 32'h0,       0, 32'h0,         0, 32'h500,       1, 0, 32'h102,     0);
    add(1, 1, 0, 32'h0,       0, 32'h0,         0, 32'h500,       1, 0, 32'h102,     0);
    add(0, 1, 0, 32'h0,       0, 32'h0,         1, 32'h500,       1, 0, 32'h102,     0);
    add(0, 1, 0, 32'h0,       1, 32'hFFFFFFFC,  1, 32'h504,       1, 0, 32'h102,     1);
    add(0, 1, 0, 32'h0,       0, 32'h0,         1, 32'hFFFFFFFC,  0, 0, 32'h102,     0); // wrap
    add(0, 0, 1, 32'h600,     0, 32'h0,         1, 32'h0,         0, 0, 32'h102,     0); // r23 blocked
    add(0, 0, 0, 32'h0,       1, 32'h700,       1, 32'h0,         0, 0, 32'h102,     0); // newer trap overwrites
    add(0, 1, 0, 32'h0,       0, 32'h0,         1, 32'h0,         0, 0, 32'h102,     1);
    add(0, 0, 1, 32'h800,     0, 32'h0,         1, 32'h700,       1, 0, 32'h102,     0);
    add(0, 1, 1, 32'h900,     0, 32'h0,         1, 32'h700,       1, 0, 32'h102,     1); // live beats pending
    add(0, 0, 1, 32'h903,     0, 32'h0,         1, 32'h900,       0, 0, 32'h102,     0); // bad target parked
    add(0, 1, 0, 32'h0,       0, 32'h0,         1, 32'h900,       0, 0, 32'h102,     0); // rejected after fire
    add(0, 1, 1, 32'hA00,     0, 32'h0,         0, 32'h900,       0, 1, 32'h903,     1); // aligned redirect exits
    add(0, 1, 0, 32'h0,       0, 32'h0,         1, 32'hA00,       1, 0, 32'h903,     0);

    drive(1, 0, 1, 0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #1;
    chk_out("reset", 0, 32'h0, 0, 0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk_i);
      drive(0, tbl[i].stall, tbl[i].ready, tbl[i].rv, tbl[i].rt, tbl[i].tv, tbl[i].tvec);
      #1;
      chk_out($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_ep,
              tbl[i].e_mis, tbl[i].e_bad);
      if (tbl[i].e_valid && tbl[i].ready) e_fetch++;
      if (tbl[i].app) e_redir++;
      if (tbl[i].stall) e_stall++;
      $display("row%0d: pc=%h epoch=%0d valid=%0d mis=%0d", i, pc_o, epoch_o, req_valid_o, misaligned_o);
    end

    @(negedge clk_i);
`ifdef PC_GEN_PERF_CNT_EN
    chk("fetch_cnt",    fetch_cnt_o,    32'(e_fetch));
    chk("redirect_cnt", redirect_cnt_o, 32'(e_redir));
    chk("stall_cnt",    stall_cnt_o,    32'(e_stall));
`endif

    // Reset while blocked with a redirect parked: pending must be dropped.
    drive(0, 0, 0, 1, 32'hB00, 0, 32'h0);
    #1;
    chk_out("rst_seq blocked", 1, 32'hA04, 1, 0, 32'h903);
    @(negedge clk_i);
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
    @(negedge clk_i);
    drive(0, 0, 1, 0, 32'h0, 0, 32'h0);
    #1;
    chk_out("rst_seq boot", 0, 32'h0, 0, 0, 32'h0);
`ifdef PC_GEN_PERF_CNT_EN
    chk("rst_seq fetch_cnt", fetch_cnt_o, 32'h0);
    chk("rst_seq redirect_cnt", redirect_cnt_o, 32'h0);
`endif
    @(negedge clk_i); #1;
    chk_out("rst_seq run", 1, 32'h0, 0, 0, 32'h0);
    @(negedge clk_i); #1;
    chk_out("rst_seq advance", 1, 32'h4, 0, 0, 32'h0);
    $display("rst_seq: pc=%h epoch=%0d", pc_o, epoch_o);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
